// File: rtl/seg7_scan_reader.sv
// Recovers BCD digits from a multiplexed 7-segment display bus, filters each
// digit for stability and hands complete frames out through valid/ready.
module seg7_scan_reader #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   dig_in,
    output logic [4*NDIG-1:0] bcd_out,
    output logic [NDIG-1:0]   blank_out,
    output logic              err_out,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;
    localparam int         CW         = 4;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);

    logic [6:0]      s_seg;
    logic [NDIG-1:0] s_dig;
    logic [NDIG-1:0] p_dig;

    logic [6:0]      last_pat   [NDIG];
    logic [CW-1:0]   cnt        [NDIG];
    logic [3:0]      staged_val [NDIG];
    logic [NDIG-1:0] staged_blank;
    logic [NDIG-1:0] staged_err;
    logic [NDIG-1:0] committed;
    logic            mh_flag;
    logic [0:0]      state;

    logic [3:0]      dec_val;
    logic            dec_blank;
    logic            dec_err;
    logic            scan_ev;
    logic            multi_hot;
    logic [CW-1:0]   cnt_upd    [NDIG];
    logic [NDIG-1:0] commit_now;
    logic            do_load;

    // Input registers; p_dig lets a held strobe count as a single scan.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg <= '0;
            s_dig <= '0;
            p_dig <= '0;
        end else begin
            s_seg <= seg_in;
            s_dig <= dig_in;
            p_dig <= s_dig;
        end
    end

    assign scan_ev   = $onehot(s_dig) && (s_dig != p_dig);
    assign multi_hot = (s_dig != '0) && !$onehot(s_dig);

    // NOTE: every always_comb output gets a default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        dec_val   = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (s_seg)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            7'b0000000: dec_blank = 1'b1;
            default: begin
                dec_val = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        commit_now = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (s_seg == last_pat[k])
                cnt_upd[k] = (cnt[k] >= CNT_MAX) ? CNT_MAX : cnt[k] + CW'(1);
            else
                cnt_upd[k] = CW'(1);
            commit_now[k] = scan_ev && s_dig[k] && (cnt_upd[k] == CNT_MAX);
        end
    end

    // A frame loads as soon as every digit is committed, unless one is still
    // being held for a consumer that has not accepted it yet.
    assign do_load = (&committed) && ((state == ST_COLLECT) || out_ready);

    // NOTE: the small per-digit arrays are reset explicitly because the
    // filter must restart from a known count after reset; they are flops,
    // not a RAM, so resetting them costs nothing structurally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NDIG; k++) begin
                last_pat[k]   <= '0;
                cnt[k]        <= '0;
                staged_val[k] <= '0;
            end
            staged_blank <= '0;
            staged_err   <= '0;
        end else begin
            for (int k = 0; k < NDIG; k++) begin
                if (scan_ev && s_dig[k]) begin
                    last_pat[k] <= s_seg;
                    cnt[k]      <= cnt_upd[k];
                end
                if (commit_now[k]) begin
                    staged_val[k]   <= dec_val;
                    staged_blank[k] <= dec_blank;
                    staged_err[k]   <= dec_err;
                end
            end
        end
    end

    // Fresh commits and multi-hot sightings win over the clear done by a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            committed <= '0;
            mh_flag   <= 1'b0;
        end else begin
            committed <= (do_load ? '0 : committed) | commit_now;
            mh_flag   <= (do_load ? 1'b0 : mh_flag) | multi_hot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_COLLECT;
            out_valid <= 1'b0;
            bcd_out   <= '0;
            blank_out <= '0;
            err_out   <= 1'b0;
        end else begin
            if (do_load) begin
                for (int k = 0; k < NDIG; k++)
                    bcd_out[4*k +: 4] <= staged_val[k];
                blank_out <= staged_blank;
                err_out   <= (|staged_err) | mh_flag;
            end
            case (state)
                ST_COLLECT: begin
                    if (do_load) begin
                        state     <= ST_HOLD;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    if (out_ready && !do_load) begin
                        state     <= ST_COLLECT;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader: table-driven frames, directed
// corner sequences and a randomized scan checked against an event-level model.
module tb_seg7_scan_reader;

    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011, PB = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_in = '0;
    logic [15:0] bcd_out;
    logic [3:0]  blank_out;
    logic        err_out;
    logic        out_valid;
    logic        out_ready = 1'b1;

    seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_in(dig_in),
        .bcd_out(bcd_out), .blank_out(blank_out), .err_out(err_out),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  blank;
        logic        err;
    } frame_t;

    typedef struct {
        string       name;
        logic [27:0] pats;
        frame_t      exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    frame_t got [$];
    frame_t expq [$];
    logic [6:0] pat_tab [0:9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every transfer (valid and ready at the coming edge) is captured mid-cycle.
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready)
            got.push_back('{bcd: bcd_out, blank: blank_out, err: err_out});
    end

    task automatic dwell(input logic [3:0] d, input logic [6:0] s, input int n);
        seg_in = s;
        dig_in = d;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic scan_round(input logic [27:0] pats);
        for (int k = NDIG - 1; k >= 0; k--)
            dwell(4'(1 << k), pats[7*k +: 7], 4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        dig_in = '0;
        seg_in = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got.delete();
    endtask

    // Reference decode: table lookup, blank, otherwise invalid.
    function automatic logic [5:0] ref_decode(input logic [6:0] p);
        if (p == 7'b0) return {1'b0, 1'b1, 4'h0};
        for (int d = 0; d < 10; d++)
            if (pat_tab[d] == p) return {1'b0, 1'b0, 4'(d)};
        return {1'b1, 1'b0, 4'hF};
    endfunction

    vec_t vecs [5];

    // Event-level reference state for the random run.
    logic [6:0] m_last [NDIG];
    int         m_cnt  [NDIG];
    logic [5:0] m_dec  [NDIG];
    logic [3:0] m_comm;
    logic       m_flag;
    logic [3:0] m_prev;

    task automatic model_dwell(input logic [3:0] d, input logic [6:0] p);
        if ($countones(d) > 1) begin
            m_flag = 1'b1;
        end else if (d != 4'b0 && d != m_prev) begin
            for (int k = 0; k < NDIG; k++) begin
                if (d[k]) begin
                    if (p == m_last[k]) m_cnt[k] = (m_cnt[k] + 1 > STABLE) ? STABLE : m_cnt[k] + 1;
                    else begin
                        m_last[k] = p;
                        m_cnt[k]  = 1;
                    end
                    if (m_cnt[k] == STABLE) begin
                        m_comm[k] = 1'b1;
                        m_dec[k]  = ref_decode(p);
                    end
                end
            end
            if (m_comm == 4'hF) begin
                frame_t f;
                f.err = m_flag;
                for (int k = 0; k < NDIG; k++) begin
                    f.bcd[4*k +: 4] = m_dec[k][3:0];
                    f.blank[k]      = m_dec[k][4];
                    f.err           = f.err | m_dec[k][5];
                end
                expq.push_back(f);
                m_comm = 4'b0;
                m_flag = 1'b0;
            end
        end
        m_prev = d;
    endtask

    initial begin
        pat_tab[0] = P0; pat_tab[1] = P1; pat_tab[2] = P2; pat_tab[3] = P3; pat_tab[4] = P4;
        pat_tab[5] = P5; pat_tab[6] = P6; pat_tab[7] = P7; pat_tab[8] = P8; pat_tab[9] = P9;

        vecs[0] = '{"v2024",  {P2, P0, P2, P4},               '{16'h2024, 4'b0000, 1'b0}};
        vecs[1] = '{"vbadbl", {P8, PB, 7'b1000001, P8},       '{16'h80F8, 4'b0100, 1'b1}};
        vecs[2] = '{"v9753",  {P9, P7, P5, P3},               '{16'h9753, 4'b0000, 1'b0}};
        vecs[3] = '{"vblank", {PB, PB, PB, PB},               '{16'h0000, 4'b1111, 1'b0}};
        vecs[4] = '{"v61f0",  {P6, P1, 7'b0000001, P0},       '{16'h61F0, 4'b0000, 1'b1}};

        // Reset state.
        do_reset();
        #1;
        check("reset_outputs", {bcd_out, blank_out, err_out, out_valid}, '0);

        // Table-driven frames: nothing after two rounds, one frame after three.
        foreach (vecs[i]) begin
            do_reset();
            out_ready = 1'b1;
            scan_round(vecs[i].pats);
            scan_round(vecs[i].pats);
            check({vecs[i].name, "_early"}, 64'(got.size()), 64'd0);
            scan_round(vecs[i].pats);
            dwell(4'b0, 7'b0, 3);
            check({vecs[i].name, "_count"}, 64'(got.size()), 64'd1);
            if (got.size() > 0) check({vecs[i].name, "_frame"}, 64'(got[0]), 64'(vecs[i].exp));
        end

        // Latency: valid rises on the third edge after the final strobe.
        do_reset();
        scan_round({P2, P0, P2, P4});
        scan_round({P2, P0, P2, P4});
        dwell(4'b1000, P2, 4);
        dwell(4'b0100, P0, 4);
        dwell(4'b0010, P2, 4);
        seg_in = P4;
        dig_in = 4'b0001;
        @(posedge clk); #1;
        check("lat_e0", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_e1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("lat_e2", {out_valid, bcd_out}, {1'b1, 16'h2024});
        @(negedge clk);
        dwell(4'b0, 7'b0, 3);

        // Digit 0 flips every scan, so no frame ever completes.
        do_reset();
        for (int r = 0; r < 20; r++)
            scan_round({P8, P8, P8, (r % 2 == 0) ? P1 : P7});
        check("flicker_frames", {31'(got.size()), out_valid}, 32'd0);

        // Held frame stays frozen while digit 0 changes; one ready cycle reloads.
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) scan_round({P1, P2, P3, P5});
        dwell(4'b0, 7'b0, 3);
        check("hold_first", {out_valid, bcd_out}, {1'b1, 16'h1235});
        for (int r = 0; r < 10; r++) begin
            scan_round({P1, P2, P3, P6});
            check("hold_frozen", {out_valid, bcd_out}, {1'b1, 16'h1235});
        end
        dwell(4'b0, 7'b0, 2);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("b2b_reload", {out_valid, bcd_out}, {1'b1, 16'h1236});
        check("b2b_transfer", {31'(got.size()), got.size() > 0 ? (got[0].bcd == 16'h1235) : 1'b0}, {31'd1, 1'b1});
        out_ready = 1'b1;
        dwell(4'b0, 7'b0, 3);
        check("b2b_drained", 64'(out_valid), 64'd0);

        // Multi-hot dwell mid-scan: no filter effect, error on the next frame only.
        do_reset();
        dwell(4'b1000, P4, 4);
        dwell(4'b0100, P5, 4);
        dwell(4'b0010, P6, 4);
        dwell(4'b0011, P6, 4);
        dwell(4'b0001, P7, 4);
        scan_round({P4, P5, P6, P7});
        check("mh_early", 64'(got.size()), 64'd0);
        scan_round({P4, P5, P6, P7});
        dwell(4'b0, 7'b0, 3);
        check("mh_count", 64'(got.size()), 64'd1);
        if (got.size() > 0) check("mh_frame", 64'(got[0]), 64'({16'h4567, 4'b0000, 1'b1}));
        scan_round({P4, P5, P6, P7});
        dwell(4'b0, 7'b0, 3);
        check("mh_cleared", 64'(got.size() > 1 ? got[1] : '0), 64'({16'h4567, 4'b0000, 1'b0}));

        // Asynchronous reset while a frame is held.
        do_reset();
        out_ready = 1'b0;
        for (int r = 0; r < 3; r++) scan_round({PB, 7'b0000011, P2, P4});
        dwell(4'b0, 7'b0, 2);
        check("pre_reset", {out_valid, bcd_out, blank_out, err_out}, {1'b1, 16'h0F24, 4'b1000, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {out_valid, bcd_out, blank_out, err_out}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        got.delete();
        scan_round({PB, 7'b0000011, P2, P4});
        scan_round({PB, 7'b0000011, P2, P4});
        check("post_reset_early", {31'(got.size()), out_valid}, 32'd0);
        scan_round({PB, 7'b0000011, P2, P4});
        dwell(4'b0, 7'b0, 3);
        check("post_reset_frame", 64'(got.size()), 64'd1);

        // Randomized scan against the event-level model.
        do_reset();
        out_ready = 1'b1;
        expq.delete();
        for (int k = 0; k < NDIG; k++) begin
            m_last[k] = '0;
            m_cnt[k]  = 0;
            m_dec[k]  = '0;
        end
        m_comm = '0;
        m_flag = 1'b0;
        m_prev = '0;
        begin
            logic [6:0] cur [NDIG];
            for (int k = 0; k < NDIG; k++) cur[k] = pat_tab[$urandom_range(0, 9)];
            for (int n = 0; n < 500; n++) begin
                int r;
                logic [3:0] d;
                logic [6:0] p;
                r = $urandom_range(0, 99);
                if (r < 5) begin
                    int a, b;
                    a = $urandom_range(0, 3);
                    b = (a + $urandom_range(1, 3)) % 4;
                    d = 4'((1 << a) | (1 << b));
                    p = 7'($urandom);
                end else if (r < 10) begin
                    d = 4'b0;
                    p = 7'b0;
                end else begin
                    int k;
                    int o;
                    k = $urandom_range(0, 3);
                    if ($urandom_range(0, 99) < 15) begin
                        o = $urandom_range(0, 11);
                        cur[k] = (o < 10) ? pat_tab[o] : ((o == 10) ? 7'b0 : 7'b1000001);
                    end
                    d = 4'(1 << k);
                    p = cur[k];
                end
                model_dwell(d, p);
                dwell(d, p, $urandom_range(2, 4));
            end
        end
        dwell(4'b0, 7'b0, 6);
        check("rand_count", 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            check("rand_frame", 64'(got[i]), 64'(expq[i]));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
Reads back a multiplexed 7-segment display bus (one-hot digit strobe plus shared active-high segments a..g, blank = all segments off) and recovers the BCD digit shown on each position. It is the inverse of the team's BCD-to-7-segment decoder and is used for display loop-back self-test and for capturing external scanned displays. A per-digit stability filter rejects ghosting and transients. Recovered frames are delivered through a valid/ready handshake.

Parameters:
NDIG, 4, number of scanned digit positions (1..8)
STABLE, 3, consecutive identical scans of a digit required before its value is accepted (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
seg_in  in  7  segment levels, active high; seg_in[6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g
dig_in  in  NDIG  digit strobe, one-hot; dig_in[k]=1 means seg_in currently shows digit k
bcd_out  out  4*NDIG  recovered digits; digit k at bcd_out[4k+3:4k]
blank_out  out  NDIG  bit k = digit k was blank (all segments off)
err_out  out  1  frame contains at least one invalid pattern or a multi-hot strobe was seen
out_valid  out  1  frame on bcd_out/blank_out/err_out is valid
out_ready  in  1  consumer accepts frame

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low; it clears all state immediately and is released synchronously by the system.
- Reset values: bcd_out=0, blank_out=0, err_out=0, out_valid=0, FSM=COLLECT. All internal registers are 0: input regs, previous strobe, last_pat[k], cnt[k], committed[k], staged values, sticky multi-hot flag.
- Input stage: seg_in and dig_in are registered once (s_seg, s_dig). p_dig holds the previous s_dig.
- Scan event for digit k: s_dig is one-hot with bit k set and s_dig != p_dig. Zero-hot s_dig means idle, with no event. Multi-hot s_dig generates no event and sets the sticky multi-hot flag.
- Pattern decode, a..g order:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 0000000 = blank: value 0, blank bit 1.
  - Any other pattern = invalid: value 4'hF, digit error bit 1.
- Stability filter, on a scan event for digit k with pattern p:
  - If p == last_pat[k], then cnt[k] = min(cnt[k]+1, STABLE).
  - Otherwise last_pat[k] = p and cnt[k] = 1.
  - If the updated cnt[k] == STABLE, then committed[k] = 1 and staged[k] = decode(p). Staged values are overwritten by later stable scans.
- FSM, two states:
  - COLLECT (out_valid=0): when all committed bits are 1, load the outputs from staged values and go to HOLD. Loading sets err_out = (any staged digit error) OR sticky flag, then clears all committed bits and the sticky flag.
  - HOLD (out_valid=1): outputs are frozen. On out_ready=1, the frame transfers. If all committed bits are 1 in that same cycle, reload back-to-back and stay in HOLD with out_valid still 1. Otherwise go to COLLECT.
  - Scanning and filtering continue during HOLD. Only the newest staged values are used at the next load.
- Latency: strobe for the final needed digit presented before edge E0 → registered at E0 → committed at E1 → out_valid=1 after E2 (3 edges).
- STABLE=1: every scan event commits.
- Simultaneous commit and transfer: handled as in HOLD above, with no lost frame or bubble.
- Reset mid-operation: out_valid drops immediately. A fresh frame then requires STABLE full scan rounds.

Test Plan:
1. NDIG=4, STABLE=3, out_ready=1. Scan digits 3..0 showing 2,0,2,4 (1101101, 1111110, 1101101, 0110011) for 3 rounds, each strobe held 4 cycles → out_valid pulses with bcd_out=16'h2024, blank_out=0, err_out=0, out_valid rising 3 edges after the last strobe's presentation.
2. Digit 0 alternates 0110000/1110000 on every scan, other digits stable → cnt[0] never exceeds 1, out_valid stays 0 for 20 rounds.
3. Digit 1 shows 1000001, digit 2 shows 0000000, others 8 → bcd_out[7:4]=F, blank_out=0100, err_out=1.
4. out_ready=0 for 10 rounds while digit 0 changes from 5 to 6 → held frame unchanged with out_valid=1. Raise out_ready for one cycle → next frame shows digit 0 = 6 and out_valid stays 1 (back-to-back).
5. dig_in=0011 for one dwell within an otherwise valid scan → no counter change, and the next frame has err_out=1.
6. Assert rst_n=0 asynchronously while out_valid=1 → all outputs 0 before the next clock edge. After release, first out_valid only after 3 complete rounds.
